// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with valid/ready handshake and packet-locked channel select.
// Optional per-channel delivered-beat counters are enabled by defining DEMUX_BEAT_CNT_EN.
module stream_demux_1xn #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_CH   = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [SEL_W-1:0]   s,
    output logic [N_CH-1:0]    out_valid,
    input  logic [N_CH-1:0]    out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
`ifdef DEMUX_BEAT_CNT_EN
    input  logic               cnt_clr,
    output logic [N_CH*16-1:0] beat_cnt,
`endif
    output logic               err_drop
);

    typedef enum logic [1:0] {StIdle, StLocked, StDrop} state_e;

    state_e              state_q, state_d;
    logic                full_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_pkt_q;
    logic [DATA_W-1:0]   data_q;
    logic                last_q;
    logic                err_q;

    logic                sel_ready;
    logic                accept;
    logic                s_in_range;
    logic                drop_beat;
    logic                write;
    logic                drain;
    logic [SEL_W-1:0]    beat_sel;

    // Ready of the channel currently held in the output register.
    always_comb begin
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = out_ready[i];
            end
        end
    end

    always_comb begin
        s_in_range = 32'(s) < N_CH;
        in_ready   = (state_q == StDrop) | ~full_q | sel_ready;
        accept     = in_valid & in_ready;
        beat_sel   = (state_q == StIdle) ? s : sel_pkt_q;
        drop_beat  = (state_q == StDrop) | ((state_q == StIdle) & ~s_in_range);
        write      = accept & ~drop_beat;
        drain      = full_q & sel_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !in_last) begin
                    state_d = s_in_range ? StLocked : StDrop;
                end
            end
            StLocked, StDrop: begin
                if (accept && in_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            full_q    <= 1'b0;
            sel_q     <= '0;
            sel_pkt_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // A simultaneous drain and fill keeps the register full with the new beat.
            full_q  <= write | (full_q & ~drain);
            err_q   <= accept & drop_beat;
            if (write) begin
                sel_q  <= beat_sel;
                data_q <= in_data;
                last_q <= in_last;
            end
            if (accept && state_q == StIdle) begin
                sel_pkt_q <= s;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            out_valid[i] = full_q & (sel_q == SEL_W'(i));
        end
    end

    assign out_data = data_q;
    assign out_last = last_q;
    assign err_drop = err_q;

`ifdef DEMUX_BEAT_CNT_EN
    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (cnt_clr) begin
                cnt_q <= '0;
            end else if (out_valid[i] && out_ready[i]) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign beat_cnt[i*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn (N_CH=6 so select values 6 and 7 are out of range).
// Counter checks are compiled in only when DEMUX_BEAT_CNT_EN is defined.
module tb_stream_demux_1xn;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 6;
    localparam int unsigned SW  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           in_last;
    logic [SW-1:0]  s;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           err_drop;
`ifdef DEMUX_BEAT_CNT_EN
    logic              cnt_clr;
    logic [NCH*16-1:0] beat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    stream_demux_1xn #(.DATA_W(DW), .N_CH(NCH), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef DEMUX_BEAT_CNT_EN
        .cnt_clr   (cnt_clr),
        .beat_cnt  (beat_cnt),
`endif
        .err_drop  (err_drop)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: a pending-beat queue (0 or 1 entry), packet mode and a delivery log.
    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t       pend[$];
    beat_t       log_q[$];
    int          pkt_state = 0;  // 0 no packet, 1 delivering, 2 discarding
    int          pkt_ch = 0;
    bit          err_exp = 1'b0;
    logic [15:0] cnt_m [NCH];

    initial foreach (cnt_m[i]) cnt_m[i] = 16'd0;

    function bit m_ready();
        return (pkt_state == 2) || (pend.size() == 0) || (out_ready[pend[0].ch] == 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit    rdy, acc, first, dropping, delivered, clr_now;
        int    dch;
        beat_t b;
        if (!rst_n) begin
            pend.delete();
            pkt_state = 0;
            err_exp   = 1'b0;
            foreach (cnt_m[i]) cnt_m[i] = 16'd0;
        end else begin
            rdy       = m_ready();
            acc       = in_valid && rdy;
            delivered = 1'b0;
            dch       = 0;
            clr_now   = 1'b0;
`ifdef DEMUX_BEAT_CNT_EN
            clr_now   = cnt_clr;
`endif
            if (pend.size() > 0 && out_ready[pend[0].ch]) begin
                dch       = pend[0].ch;
                delivered = 1'b1;
                log_q.push_back(pend.pop_front());
            end
            if (clr_now) foreach (cnt_m[i]) cnt_m[i] = 16'd0;
            else if (delivered) cnt_m[dch] = cnt_m[dch] + 16'd1;
            err_exp = 1'b0;
            if (acc) begin
                first    = (pkt_state == 0);
                b.ch     = first ? int'(s) : pkt_ch;
                b.data   = in_data;
                b.last   = in_last;
                dropping = (pkt_state == 2) || (first && int'(s) >= int'(NCH));
                if (dropping) err_exp = 1'b1;
                else pend.push_back(b);
                if (in_last) pkt_state = 0;
                else if (first) begin
                    pkt_state = dropping ? 2 : 1;
                    pkt_ch    = int'(s);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] ev;
        if (rst_n) begin
            ev = '0;
            if (pend.size() > 0) ev[pend[0].ch] = 1'b1;
            check("in_ready", in_ready, m_ready());
            check("out_valid", out_valid, ev);
            if (pend.size() > 0) begin
                check("out_data", out_data, pend[0].data);
                check("out_last", out_last, pend[0].last);
            end
            check("err_drop", err_drop, err_exp);
`ifdef DEMUX_BEAT_CNT_EN
            for (int i = 0; i < int'(NCH); i++) check("beat_cnt", beat_cnt[i*16 +: 16], cnt_m[i]);
`endif
            if (err_drop) err_pulses++;
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input logic [2:0] sel);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        s        = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input int idx, input int ch, input logic [7:0] d,
                              input bit l);
        if (idx < log_q.size()) begin
            check({name, "_ch"}, log_q[idx].ch, ch);
            check({name, "_data"}, log_q[idx].data, d);
            check({name, "_last"}, log_q[idx].last, l);
        end else begin
            check({name, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        int e0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_last   = 1'b0;
        s         = 3'd0;
        out_ready = '1;
`ifdef DEMUX_BEAT_CNT_EN
        cnt_clr   = 1'b0;
`endif
        // Reset held with a valid beat presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_drop", err_drop, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Single-beat packets on every select value
        base = log_q.size();
        e0   = err_pulses;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b1, i[2:0]);
            @(negedge clk);
            check("sb_valid", out_valid, (i < 6) ? 6'(1 << i) : 6'd0);
            check("sb_err", err_drop, (i >= 6) ? 1 : 0);
            if (i < 6) check("sb_data", out_data, 8'(8'hA0 + i));
        end
        idle(2);
        for (int i = 0; i < 6; i++) check_beat("sb_log", base + i, i, 8'(8'hA0 + i), 1'b1);
        @(negedge clk);
        check("sb_err_count", err_pulses - e0, 2);

        // Four-beat packet: select locked to channel 5
        base = log_q.size();
        drive(1'b1, 8'h11, 1'b0, 3'd5);
        drive(1'b1, 8'h12, 1'b0, 3'd2);
        drive(1'b1, 8'h13, 1'b0, 3'd2);
        drive(1'b1, 8'h14, 1'b1, 3'd2);
        idle(2);
        check_beat("pk4_b0", base + 0, 5, 8'h11, 1'b0);
        check_beat("pk4_b1", base + 1, 5, 8'h12, 1'b0);
        check_beat("pk4_b2", base + 2, 5, 8'h13, 1'b0);
        check_beat("pk4_b3", base + 3, 5, 8'h14, 1'b1);

        // Stall on channel 3
        base      = log_q.size();
        out_ready = 6'b110111;
        drive(1'b1, 8'h31, 1'b0, 3'd3);
        in_data = 8'h32;
        s       = 3'd0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 6'b001000);
            check("stall_data", out_data, 8'h31);
            @(posedge clk);
            #1;
        end
        out_ready = '1;
        @(posedge clk);
        #1;
        drive(1'b1, 8'h33, 1'b1, 3'd0);
        idle(2);
        check_beat("stall_b0", base + 0, 3, 8'h31, 1'b0);
        check_beat("stall_b1", base + 1, 3, 8'h32, 1'b0);
        check_beat("stall_b2", base + 2, 3, 8'h33, 1'b1);
        check("stall_count", log_q.size() - base, 3);

        // Out-of-range packet discarded, following packet delivered
        base = log_q.size();
        e0   = err_pulses;
        drive(1'b1, 8'h71, 1'b0, 3'd7);
        @(negedge clk);
        check("oor_err0", err_drop, 1);
        check("oor_valid0", out_valid, 0);
        drive(1'b1, 8'h72, 1'b1, 3'd3);
        @(negedge clk);
        check("oor_err1", err_drop, 1);
        check("oor_valid1", out_valid, 0);
        drive(1'b1, 8'h81, 1'b1, 3'd1);
        @(negedge clk);
        check("oor_next_valid", out_valid, 6'b000010);
        check("oor_next_data", out_data, 8'h81);
        check("oor_next_err", err_drop, 0);
        idle(2);
        check_beat("oor_log", base, 1, 8'h81, 1'b1);
        check("oor_log_count", log_q.size() - base, 1);
        @(negedge clk);
        check("oor_err_count", err_pulses - e0, 2);

        // Reset mid-packet: next beat is a first beat again
        base = log_q.size();
        drive(1'b1, 8'h91, 1'b0, 3'd2);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h92, 1'b1, 3'd4);
        @(negedge clk);
        check("midrst_next_valid", out_valid, 6'b010000);
        check("midrst_next_data", out_data, 8'h92);
        idle(2);
        check_beat("midrst_log", base, 4, 8'h92, 1'b1);

`ifdef DEMUX_BEAT_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        drive(1'b1, 8'h01, 1'b1, 3'd0);
        drive(1'b1, 8'h02, 1'b1, 3'd0);
        drive(1'b1, 8'h03, 1'b1, 3'd0);
        drive(1'b1, 8'h04, 1'b1, 3'd4);
        idle(2);
        @(negedge clk);
        check("cnt_values", beat_cnt, {16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3});
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_cleared", beat_cnt, 96'd0);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
Registered 1-to-N stream demultiplexer with valid/ready handshake, parametrised data width and channel count. It routes each beat from a single input stream to the output channel selected by `s`. Selection is held for a whole packet: it is sampled on the first beat and released after the beat carrying `in_last`. It is the sequential, back-pressure-aware successor to the combinational 1xN demux chain, used wherever a producer fans out to several consumers.

Parameters:
DATA_W, 8, width of in_data / out_data
N_CH, 8, number of output channels (2..16)
SEL_W, 3, width of s; must satisfy 2**SEL_W >= N_CH

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
in_data  input  DATA_W  input beat payload
in_last  input  1  marks final beat of a packet
s  input  SEL_W  channel select, sampled on first beat of a packet only
out_valid  output  N_CH  one-hot per-channel valid; at most one bit set
out_ready  input  N_CH  per-channel ready
out_data  output  DATA_W  shared payload bus, meaningful for the channel whose out_valid is set
out_last  output  1  last flag accompanying out_data
err_drop  output  1  one-cycle pulse when a beat is dropped (select out of range)

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_last=0, err_drop=0.
  - FSM state IDLE; holding register empty.
  - in_ready goes to 1 once rst_n deasserts.
- Single-entry output register (`full` flag, `sel_q`, `data_q`, `last_q`).
  - Latency: a beat accepted in cycle k appears on its channel in cycle k+1.
- in_ready = !full | out_ready[sel_q]. This is combinational from out_ready and gives full throughput when the consumer is ready.
- out_valid[i] = full & (sel_q==i). out_data=data_q, out_last=last_q.
- Output contents are stable while out_valid[i] & !out_ready[i]. No drop, no change.
- FSM states:
  - IDLE, no packet open. On accept: sel_pkt <= s.
    - If s < N_CH and !in_last: go to LOCKED.
    - If in_last (single-beat packet): stay IDLE.
  - LOCKED, packet open. Every accepted beat uses sel_pkt and s is ignored. On accept with in_last: go to IDLE.
- Out-of-range select (s >= N_CH on a first beat):
  - The beat is accepted (in_ready follows the normal rule) but not written to the register.
  - err_drop pulses 1 for one cycle.
  - The FSM enters DROP if !in_last. In DROP, in_ready=1 and every beat is discarded with an err_drop pulse. Accepting in_last returns to IDLE.
- Simultaneous drain and fill on the same edge:
  - The register is reloaded with the new beat; full stays 1.
  - The new beat's channel may differ from the old one only across a packet boundary.
- A channel whose out_ready is stuck low stalls the whole demux. This is intentional head-of-line blocking.
- Reset mid-packet: the register is cleared, the FSM goes to IDLE and the partial packet is lost. The next accepted beat is treated as a first beat.

Optional Feature:
DEMUX_BEAT_CNT_EN
- When defined:
  - Adds output beat_cnt [N_CH*16-1:0]. This is a per-channel 16-bit count of beats delivered (out_valid[i]&out_ready[i]).
  - Adds input cnt_clr. When 1 it clears all counters synchronously; clear wins over increment.
  - Counters wrap 0xFFFF -> 0 and reset to 0.
- When undefined:
  - Neither port exists and no counter logic is generated.
  - Behaviour is otherwise identical.

Test Plan:
- Reset with in_valid=1 and rst_n=0 -> out_valid=0, out_data=0, err_drop=0. in_ready=1 on the first cycle after release.
- Single-beat packets, s=0..7, in_last=1, all out_ready=1, in_data=0xA0+s -> one beat per cycle. Each out_valid is one-hot 1<<s, one cycle later, with out_data=0xA0+s.
- 4-beat packet, s=5 on beat 0, s toggled to 2 on beats 1-3, data 0x11..0x14 -> all four beats on channel 5 in order. out_last=1 only on 0x14.
- Packet on channel 3 with out_ready[3] held 0 for 3 cycles -> out_valid[3] and out_data held constant. in_ready=0 during the stall. No beat lost or duplicated after out_ready[3]=1.
- N_CH=6, s=7, 2-beat packet -> err_drop pulses on both beats, out_valid stays 0. The following packet with s=1 is delivered normally.
- With DEMUX_BEAT_CNT_EN: deliver 3 beats to ch0 and 1 to ch4 -> beat_cnt ch0=3, ch4=1, others 0. Pulsing cnt_clr -> all zero.
